// File: rtl/vga_pkg.sv
// Shared timing defaults and state type for the VGA frame scanner.
// Default geometry is 640x480@60 with a 256x256 grey image at top-left.
package vga_pkg;

    localparam int DEF_CLK_DIV  = 2;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP
                                + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP
                                + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_IMG_W    = 256;
    localparam int DEF_IMG_H    = 256;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_PIX_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } vga_state_t;

endpackage

// File: rtl/vga_frame_scanner_if.sv
// Image memory read port plus VGA pins of the frame scanner.
// master = scanner side, slave = memory/display side.
interface vga_frame_scanner_if
    import vga_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W
);

    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_data;
    logic              hsync;
    logic              vsync;
    logic              blank_n;
    logic [PIX_W-1:0]  red;
    logic [PIX_W-1:0]  green;
    logic [PIX_W-1:0]  blue;

    modport master (
        output mem_addr,
        input  mem_data,
        output hsync,
        output vsync,
        output blank_n,
        output red,
        output green,
        output blue
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  hsync,
        input  vsync,
        input  blank_n,
        input  red,
        input  green,
        input  blue
    );

endinterface

// File: rtl/vga_timing_counter.sv
// Pixel-clock divider and h/v raster counters with raw (stage-0) timing.
// All counters are held at zero while run is low.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    output logic          pix_tick,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          vis,
    output logic          hs,
    output logic          vs,
    output logic          in_img,
    output logic          frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [DW-1:0] div_cnt;
    logic          h_last;
    logic          v_last;

    assign pix_tick  = run && (div_cnt == DW'(CLK_DIV - 1));
    assign h_last    = (h_cnt == H_LAST);
    assign v_last    = (v_cnt == V_LAST);
    assign frame_end = pix_tick && h_last && v_last;

    assign vis    = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs     = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                      (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs     = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                      (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign in_img = (h_cnt < HW'(IMG_W)) && (v_cnt < VW'(IMG_H));

    // Divide the system clock into pixel ticks and step the raster on each.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (pix_tick) begin
            div_cnt <= '0;
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/vga_frame_scanner.sv
// Scans one grey image frame out of data memory onto VGA pins per start.
// Address and sync/blank go through a pipeline matched to the sync RAM.
module vga_frame_scanner
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PIX_W    = DEF_PIX_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                vga_done,
    vga_frame_scanner_if.master bus
);

    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    vga_state_t state;
    vga_state_t state_nxt;

    logic          pix_tick;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          vis;
    logic          hs;
    logic          vs;
    logic          in_img;
    logic          frame_end;

    logic [ADDR_W-1:0] lin_addr;
    logic [ADDR_W-1:0] addr_q;

    logic vis_d;
    logic hs_d;
    logic vs_d;
    logic img_d;

    logic             hs_q;
    logic             vs_q;
    logic             blank_q;
    logic [PIX_W-1:0] pix_q;

    vga_timing_counter #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clock     (clock),
        .reset     (reset),
        .run       (state == SCAN),
        .pix_tick  (pix_tick),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .vis       (vis),
        .hs        (hs),
        .vs        (vs),
        .in_img    (in_img),
        .frame_end (frame_end)
    );

    assign lin_addr = ADDR_W'(ADDR_W'(v_cnt) * ADDR_W'(IMG_W)
                              + ADDR_W'(h_cnt));

    // Frame state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // One frame per start level; DONE waits for start to drop.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)     state_nxt = SCAN;
            SCAN:    if (frame_end) state_nxt = DONE;
            DONE:    if (!start)    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Address and stage-1 timing on one tick, pins from RAM data on the next.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            vis_d   <= 1'b0;
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
            img_d   <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            pix_q   <= '0;
        end else if (state != SCAN) begin
            if (state == IDLE && start) begin
                addr_q <= '0;
            end
            vis_d   <= 1'b0;
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
            img_d   <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            pix_q   <= '0;
        end else if (pix_tick) begin
            if (in_img) begin
                addr_q <= lin_addr;
            end
            vis_d   <= vis;
            hs_d    <= hs;
            vs_d    <= vs;
            img_d   <= in_img;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= vis_d;
            pix_q   <= (vis_d && img_d) ? bus.mem_data : '0;
        end
    end

    assign busy         = (state == SCAN);
    assign vga_done     = (state == DONE);

    assign bus.mem_addr = addr_q;
    assign bus.hsync    = hs_q;
    assign bus.vsync    = vs_q;
    assign bus.blank_n  = blank_q;
    assign bus.red      = pix_q;
    assign bus.green    = pix_q;
    assign bus.blue     = pix_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner: a default 640x480 instance for line checks
// and a shrunken instance for whole frames, both against a raster model.
module tb_vga_frame_scanner;

    typedef struct packed {
        int d;
        int ha;
        int hfp;
        int hsy;
        int hbp;
        int va;
        int vfp;
        int vsy;
        int vbp;
        int iw;
        int ih;
    } geom_t;

    localparam int S_D   = 3;
    localparam int S_HA  = 40;
    localparam int S_HFP = 4;
    localparam int S_HSY = 8;
    localparam int S_HBP = 6;
    localparam int S_VA  = 30;
    localparam int S_VFP = 2;
    localparam int S_VSY = 2;
    localparam int S_VBP = 3;
    localparam int S_IW  = 16;
    localparam int S_IH  = 16;
    localparam int S_HT  = S_HA + S_HFP + S_HSY + S_HBP;
    localparam int S_VT  = S_VA + S_VFP + S_VSY + S_VBP;
    localparam int NS    = S_D * S_HT * S_VT;

    localparam geom_t GF = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 256, 256};
    localparam geom_t GS = '{S_D, S_HA, S_HFP, S_HSY, S_HBP,
                             S_VA, S_VFP, S_VSY, S_VBP, S_IW, S_IH};

    localparam logic [28:0] IDLE_PINS = {1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0};

    logic clk     = 1'b0;
    logic rst_f   = 1'b1;
    logic rst_s   = 1'b1;
    logic start_f = 1'b1;
    logic start_s = 1'b0;
    logic busy_f;
    logic done_f;
    logic busy_s;
    logic done_s;

    vga_frame_scanner_if #(.ADDR_W(16), .PIX_W(8)) bus_f ();
    vga_frame_scanner_if #(.ADDR_W(16), .PIX_W(8)) bus_s ();

    vga_frame_scanner dut_f (
        .clock    (clk),
        .reset    (rst_f),
        .start    (start_f),
        .busy     (busy_f),
        .vga_done (done_f),
        .bus      (bus_f)
    );

    vga_frame_scanner #(
        .CLK_DIV  (S_D),
        .H_ACTIVE (S_HA),
        .H_FP     (S_HFP),
        .H_SYNC   (S_HSY),
        .H_BP     (S_HBP),
        .V_ACTIVE (S_VA),
        .V_FP     (S_VFP),
        .V_SYNC   (S_VSY),
        .V_BP     (S_VBP),
        .IMG_W    (S_IW),
        .IMG_H    (S_IH),
        .ADDR_W   (16),
        .PIX_W    (8)
    ) dut_s (
        .clock    (clk),
        .reset    (rst_s),
        .start    (start_s),
        .busy     (busy_s),
        .vga_done (done_s),
        .bus      (bus_s)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_s [256];

    always @(posedge clk) begin
        bus_f.mem_data <= bus_f.mem_addr[7:0];
        bus_s.mem_data <= mem_s[bus_s.mem_addr[7:0]];
    end

    logic [28:0] pins_f;
    logic [28:0] pins_s;

    assign pins_f = {bus_f.hsync, bus_f.vsync, bus_f.blank_n, bus_f.red,
                     bus_f.green, bus_f.blue, busy_f, done_f};
    assign pins_s = {bus_s.hsync, bus_s.vsync, bus_s.blank_n, bus_s.red,
                     bus_s.green, bus_s.blue, busy_s, done_s};

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    int ph_f = 0;
    int n_f  = 0;
    int ea_f = 0;
    int ph_s = 0;
    int n_s  = 0;
    int ea_s = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ht(input geom_t g);
        return g.ha + g.hfp + g.hsy + g.hbp;
    endfunction

    function automatic int vt(input geom_t g);
        return g.va + g.vfp + g.vsy + g.vbp;
    endfunction

    function automatic logic [7:0] pix(input bit sm, input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        return sm ? mem_s[a16[7:0]] : a16[7:0];
    endfunction

    // Address left on the bus after j pixels of the raster were consumed:
    // the most recent in-image pixel so far.
    function automatic int addr_after(input geom_t g, input int j);
        int q;
        int h;
        int v;
        int a;
        q = j - 1;
        h = q % ht(g);
        v = q / ht(g);
        if (v >= g.ih)      a = (g.ih - 1) * g.iw + g.iw - 1;
        else if (h >= g.iw) a = v * g.iw + g.iw - 1;
        else                a = v * g.iw + h;
        return a & 32'hFFFF;
    endfunction

    // Pins n clocks into a frame show the pixel two pixel periods back.
    function automatic logic [28:0] exp_pins(input geom_t g, input int ph,
                                             input int n, input bit sm);
        int p;
        int h;
        int v;
        logic hsn;
        logic vsn;
        logic vis;
        logic img;
        logic [7:0] px;
        hsn = 1'b1;
        vsn = 1'b1;
        vis = 1'b0;
        px  = 8'h0;
        if (ph == 1) begin
            p = n / g.d - 2;
            if (p >= 0) begin
                h   = p % ht(g);
                v   = p / ht(g);
                vis = (h < g.ha) && (v < g.va);
                hsn = !((h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hsy));
                vsn = !((v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vsy));
                img = (h < g.iw) && (v < g.ih);
                px  = img ? pix(sm, v * g.iw + h) : 8'h0;
            end
        end
        return {hsn, vsn, vis, px, px, px, ph == 1, ph == 2};
    endfunction

    task automatic step(input geom_t g, input logic rst, input logic st,
                        inout int ph, inout int n, inout int ea);
        int tot;
        tot = g.d * ht(g) * vt(g);
        if (rst) begin
            ph = 0;
            n  = 0;
            ea = 0;
        end else if (ph == 0) begin
            if (st) begin
                ph = 1;
                n  = 0;
                ea = 0;
            end
        end else if (ph == 1) begin
            n++;
            if (n == tot) begin
                ph = 2;
                ea = addr_after(g, ht(g) * vt(g));
            end else if (n >= g.d) begin
                ea = addr_after(g, n / g.d);
            end
        end else if (!st) begin
            ph = 0;
        end
    endtask

    always @(posedge clk) begin
        step(GF, rst_f, start_f, ph_f, n_f, ea_f);
        step(GS, rst_s, start_s, ph_s, n_s, ea_s);
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("f_pins", 32'(pins_f), 32'(exp_pins(GF, ph_f, n_f, 1'b0)));
            chk("f_addr", 32'(bus_f.mem_addr), ea_f);
            chk("s_pins", 32'(pins_s), 32'(exp_pins(GS, ph_s, n_s, 1'b1)));
            chk("s_addr", 32'(bus_s.mem_addr), ea_s);
        end
    end

    task automatic wait_pix(input bit sm, input int tgt);
        for (int k = 0; k < 200000; k++) begin
            if (sm ? (ph_s == 1 && n_s == tgt) : (ph_f == 1 && n_f == tgt))
                return;
            @(negedge clk);
        end
        chk(sm ? "s_wait" : "f_wait", sm ? n_s : n_f, tgt);
    endtask

    task automatic frame_s(input int drop);
        int cnt;
        cnt = 0;
        while (cnt < NS + 50) begin
            @(negedge clk);
            cnt++;
            if (drop > 0 && cnt == drop) start_s = 1'b0;
            if (done_s) break;
        end
        chk("s_done_lat", cnt, NS + 1);
    endtask

    task automatic run_f();
        int fall1;
        int fall2;
        int low;
        logic prev;
        fall1 = -1;
        fall2 = -1;
        low   = 0;
        rst_f = 1'b0;
        wait_pix(1'b0, 2 * (2 * 800 + 5 + 1));
        chk("f_addr_5_2", 32'(bus_f.mem_addr), 517);
        wait_pix(1'b0, 2 * (2 * 800 + 5 + 2));
        chk("f_rgb_5_2", {bus_f.blank_n, bus_f.red, bus_f.green, bus_f.blue},
            {1'b1, 24'h050505});
        wait_pix(1'b0, 2 * (3 * 800 + 2));
        prev = 1'b1;
        for (int i = 0; i < 3200; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 1600 && !bus_f.hsync) low++;
            if (prev && !bus_f.hsync) begin
                if (fall1 < 0)      fall1 = i;
                else if (fall2 < 0) fall2 = i;
            end
            prev = bus_f.hsync;
        end
        chk("f_hs_low", low, 192);
        chk("f_hs_start", fall1, 2 * 656);
        chk("f_hs_period", fall2 - fall1, 1600);
        wait_pix(1'b0, 2 * (10 * 800 + 300 + 2));
        chk("f_300_10", {bus_f.blank_n, bus_f.red}, {1'b1, 8'h0});
        wait_pix(1'b0, 2 * (10 * 800 + 700 + 2));
        chk("f_700_10", {bus_f.blank_n, bus_f.red, bus_f.green, bus_f.blue},
            {1'b0, 24'h0});
        wait_pix(1'b0, 2 * (11 * 800 + 123));
        rst_f = 1'b1;
        @(negedge clk);
        chk("f_abort", 32'(pins_f), 32'(IDLE_PINS));
        chk("f_abort_addr", 32'(bus_f.mem_addr), 0);
        start_f = 1'b0;
        @(negedge clk);
        rst_f = 1'b0;
    endtask

    task automatic run_s();
        rst_s = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        start_s = 1'b1;
        frame_s(0);
        repeat ($urandom_range(5, 40)) @(negedge clk);
        chk("s_done_hold", {busy_s, done_s}, 2'b01);
        start_s = 1'b0;
        @(negedge clk);
        chk("s_idle", {busy_s, done_s}, 2'b00);
        repeat ($urandom_range(1, 10)) @(negedge clk);
        start_s = 1'b1;
        frame_s($urandom_range(10, NS / 2));
        @(negedge clk);
        chk("s_done_drop", {busy_s, done_s}, 2'b00);
        repeat (3) @(negedge clk);
        start_s = 1'b1;
        wait_pix(1'b1, S_D * (20 * S_HT + $urandom_range(0, S_HT - 1)));
        rst_s = 1'b1;
        @(negedge clk);
        chk("s_abort", 32'(pins_s), 32'(IDLE_PINS));
        chk("s_abort_addr", 32'(bus_s.mem_addr), 0);
        rst_s = 1'b0;
        frame_s(0);
        start_s = 1'b0;
        @(negedge clk);
        chk("s_idle2", {busy_s, done_s}, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_s[i] = 8'($urandom);
        @(negedge clk);
        mon_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("f_rst_busy", 32'(busy_f), 0);
        chk("f_rst_done", 32'(done_f), 0);
        chk("f_rst_sync", {bus_f.hsync, bus_f.vsync}, 2'b11);
        chk("f_rst_addr", 32'(bus_f.mem_addr), 0);
        fork
            run_f();
            run_s();
        join
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
